// File: rtl/axis_gain_ramp_if.sv
// AXI-Stream sample bus (data/valid/ready/last) shared by both sides of the gain stage.
// Latency: none, wires only.
// Backpressure: ready travels slave->master; a beat moves when valid && ready.
interface axis_gain_ramp_if #(
    parameter int DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/axis_gain_ramp.sv
// Multi-channel AXIS gain stage: per-frame gain ramps 1 step toward target, with mute and saturation.
// Latency: 2 cycles (product stage, shift/saturate stage), 1 beat/cycle throughput.
// Backpressure: two-entry skid via per-stage valids; s_axis ready drops only when both stages are full and m_axis stalls.
module axis_gain_ramp #(
    parameter int DATA_WIDTH  = 24,
    parameter int CHANNELS    = 2,
    parameter int GAIN_WIDTH  = 8,
    parameter int RAMP_FRAMES = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [GAIN_WIDTH-1:0]  target_gain,
    input  logic                   mute,
    axis_gain_ramp_if.slave        s_axis,
    axis_gain_ramp_if.master       m_axis,
    output logic [GAIN_WIDTH-1:0]  current_gain,
    output logic                   ramp_busy,
    output logic                   frame_error
);
    localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int FW = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
    localparam logic [CW-1:0] CH_LAST = CW'(CHANNELS - 1);
    localparam logic [FW-1:0] FC_LAST = FW'(RAMP_FRAMES - 1);
    localparam logic signed [PW-1:0] Q_MAX = {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] Q_MIN = {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic [GAIN_WIDTH-1:0]  eff;
    logic [GAIN_WIDTH-1:0]  gain_next;
    logic [CW-1:0]          ch;
    logic [FW-1:0]          fc;
    logic                   accept;
    logic                   last_ch;
    logic                   boundary;
    logic                   step;
    logic                   ld1;
    logic                   ld2;
    logic                   v1;
    logic                   l1;
    logic                   v2;
    logic                   l2;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   p1;
    logic signed [PW-1:0]   q;
    logic [DATA_WIDTH-1:0]  sat;
    logic [DATA_WIDTH-1:0]  d2;

    assign eff      = mute ? '0 : target_gain;
    assign ld2      = !v2 || m_axis.ready;
    assign ld1      = !v1 || ld2;
    assign accept   = s_axis.valid && ld1;
    assign last_ch  = (ch == CH_LAST);
    assign boundary = accept && s_axis.last;
    assign step     = boundary && (fc == FC_LAST);

    assign s_axis.ready = ld1;
    assign m_axis.valid = v2;
    assign m_axis.data  = d2;
    assign m_axis.last  = l2;

    // The product uses the gain register as it stands on the acceptance cycle,
    // so a gain step taken on a frame's last beat only affects the next frame.
    assign prod = PW'($signed(s_axis.data)) * PW'($signed({1'b0, current_gain}));
    assign q    = p1 >>> (GAIN_WIDTH - 1);

    // Clamp the rescaled product into the signed output sample range.
    always_comb begin
        sat = q[DATA_WIDTH-1:0];
        if (q > Q_MAX) begin
            sat = Q_MAX[DATA_WIDTH-1:0];
        end else if (q < Q_MIN) begin
            sat = Q_MIN[DATA_WIDTH-1:0];
        end
    end

    // Next gain: one unit toward the effective target, only at a gain-step instant.
    always_comb begin
        gain_next = current_gain;
        if (step) begin
            if (current_gain < eff) begin
                gain_next = current_gain + GAIN_WIDTH'(1);
            end else if (current_gain > eff) begin
                gain_next = current_gain - GAIN_WIDTH'(1);
            end
        end
    end

    // Frame tracking: channel/frame counters, sticky framing error, gain and busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            ch           <= '0;
            fc           <= '0;
            frame_error  <= 1'b0;
            current_gain <= '0;
            ramp_busy    <= (eff != '0);
        end else begin
            if (accept) begin
                if (s_axis.last != last_ch) begin
                    frame_error <= 1'b1;
                end
                ch <= (s_axis.last || last_ch) ? '0 : ch + CW'(1);
            end
            if (boundary) begin
                fc <= (fc == FC_LAST) ? '0 : fc + FW'(1);
            end
            current_gain <= gain_next;
            ramp_busy    <= (gain_next != eff);
        end
    end

    // Two-stage datapath: stage 1 holds the raw product, stage 2 the saturated sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1 <= 1'b0;
            l1 <= 1'b0;
            p1 <= '0;
            v2 <= 1'b0;
            l2 <= 1'b0;
            d2 <= '0;
        end else begin
            if (ld1) begin
                v1 <= accept;
                if (accept) begin
                    p1 <= prod;
                    l1 <= s_axis.last;
                end
            end
            if (ld2) begin
                v2 <= v1;
                if (v1) begin
                    d2 <= sat;
                    l2 <= l1;
                end
            end
        end
    end
endmodule

// File: tb/tb_axis_gain_ramp.sv
// Randomized self-checking bench for axis_gain_ramp against a frame-level reference model.
// Latency: checks 2-cycle latency whenever the sink never stalls.
// Backpressure: random sink stalls; checks hold stability, no loss and ready behaviour.
module tb_axis_gain_ramp;
    localparam int DW = 24;
    localparam int GW = 8;
    localparam int CH = 2;
    localparam int RF = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [GW-1:0] target_gain = '0;
    logic          mute = 1'b0;
    logic [GW-1:0] current_gain;
    logic          ramp_busy;
    logic          frame_error;

    always #5 clk = ~clk;

    axis_gain_ramp_if #(.DATA_WIDTH(DW)) s_if ();
    axis_gain_ramp_if #(.DATA_WIDTH(DW)) m_if ();

    axis_gain_ramp #(
        .DATA_WIDTH  (DW),
        .CHANNELS    (CH),
        .GAIN_WIDTH  (GW),
        .RAMP_FRAMES (RF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .target_gain  (target_gain),
        .mute         (mute),
        .s_axis       (s_if.slave),
        .m_axis       (m_if.master),
        .current_gain (current_gain),
        .ramp_busy    (ramp_busy),
        .frame_error  (frame_error)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        int            cyc;
    } beat_t;

    int            n_checks = 0;
    int            n_pass = 0;
    beat_t         expq[$];
    int            m_gain = 0;
    int            m_fc = 0;
    int            m_ch = 0;
    bit            m_err = 0;
    int            cyc = 0;
    bit            lat_check = 1;
    logic [GW-1:0] prev_eff = '0;
    logic [GW-1:0] tgt_nxt = '0;
    logic          mute_nxt = 1'b0;
    bit            held = 0;
    logic [DW-1:0] held_d = '0;
    logic          held_l = 1'b0;
    int            ramp_tbl[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Spec arithmetic with plain integers: floor(x*g / 2^(GW-1)), clamped to the sample range.
    function automatic logic [DW-1:0] ref_scale(input logic [DW-1:0] x, input int g);
        longint s, q, lim;
        logic [63:0] r;
        s   = longint'($signed(x));
        q   = (s * g) >>> (GW - 1);
        lim = longint'(1) << (DW - 1);
        if (q > lim - 1) q = lim - 1;
        else if (q < -lim) q = -lim;
        r = q;
        return r[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        logic [31:0] r;
        r = $urandom();
        return r[DW-1:0];
    endfunction

    // One clock: apply inputs on the falling edge, compare, then advance the model for the coming rising edge.
    task automatic cycle(input bit v, input logic [DW-1:0] d, input bit l, input bit mr, output bit acc);
        logic [GW-1:0] eff;
        beat_t b;
        @(negedge clk);
        target_gain = tgt_nxt;
        mute = mute_nxt;
        s_if.valid = v;
        s_if.data = d;
        s_if.last = l;
        m_if.ready = mr;
        #1;
        eff = mute ? '0 : target_gain;
        check("gain", current_gain, m_gain);
        check("busy", ramp_busy, m_gain != prev_eff);
        check("frame_error", frame_error, m_err);
        check("s_ready", s_if.ready, (expq.size() < 2) || mr);
        if (held) begin
            check("hold_valid", m_if.valid, 1);
            check("hold_data", m_if.data, held_d);
            check("hold_last", m_if.last, held_l);
        end
        held = m_if.valid && !mr;
        held_d = m_if.data;
        held_l = m_if.last;
        if (m_if.valid && mr) begin
            check("queue_nonempty", expq.size() != 0, 1);
            if (expq.size() != 0) begin
                b = expq.pop_front();
                check("data", m_if.data, b.d);
                check("last", m_if.last, b.l);
                if (lat_check) check("latency", cyc - b.cyc, 2);
            end
        end
        acc = v && s_if.ready;
        if (acc) begin
            expq.push_back('{ref_scale(d, m_gain), l, cyc});
            if (l != (m_ch == CH - 1)) m_err = 1;
            m_ch = (l || m_ch == CH - 1) ? 0 : m_ch + 1;
            if (l) begin
                if (m_fc == RF - 1) begin
                    m_fc = 0;
                    if (m_gain < eff) m_gain++;
                    else if (m_gain > eff) m_gain--;
                end else begin
                    m_fc++;
                end
            end
        end
        prev_eff = eff;
        cyc++;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input bit l, input int mr_pct);
        bit acc = 0;
        for (int t = 0; t < 200 && !acc; t++) begin
            cycle(1, d, l, $urandom_range(0, 99) < mr_pct, acc);
        end
        check("accepted", acc, 1);
    endtask

    task automatic send_frame(input int mr_pct);
        for (int c = 0; c < CH; c++) send_beat(rnd_data(), c == CH - 1, mr_pct);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(0, '0, 0, 1, acc);
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 50 && expq.size() != 0; i++) cycle(0, '0, 0, 1, acc);
        check("drain", expq.size(), 0);
    endtask

    task automatic do_reset();
        logic [GW-1:0] eff;
        @(negedge clk);
        reset = 1'b1;
        s_if.valid = 1'b0;
        m_if.ready = 1'b1;
        target_gain = tgt_nxt;
        mute = mute_nxt;
        eff = mute ? '0 : target_gain;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_m_valid", m_if.valid, 0);
        check("rst_m_data", m_if.data, 0);
        check("rst_m_last", m_if.last, 0);
        check("rst_s_ready", s_if.ready, 1);
        check("rst_gain", current_gain, 0);
        check("rst_frame_error", frame_error, 0);
        check("rst_busy", ramp_busy, eff != '0);
        expq.delete();
        m_gain = 0;
        m_fc = 0;
        m_ch = 0;
        m_err = 0;
        held = 0;
        prev_eff = eff;
    endtask

    initial begin
        bit acc;
        s_if.valid = 1'b0;
        s_if.data = '0;
        s_if.last = 1'b0;
        m_if.ready = 1'b1;

        // Ramp from reset toward 4, two frames per step.
        tgt_nxt = 8'd4;
        do_reset();
        for (int f = 0; f < 10; f++) begin
            send_beat(rnd_data(), 0, 100);
            check("ramp_tbl_l", current_gain, ramp_tbl[f]);
            send_beat(rnd_data(), 1, 100);
            check("ramp_tbl_r", current_gain, ramp_tbl[f]);
        end
        idle(1);
        check("ramp_done_busy", ramp_busy, 0);

        // Mute pulls the gain to zero one step at a time, then it recovers.
        mute_nxt = 1'b1;
        for (int f = 0; f < 4 * RF; f++) send_frame(100);
        idle(1);
        check("mute_gain", current_gain, 0);
        mute_nxt = 1'b0;
        for (int f = 0; f < 4 * RF; f++) send_frame(100);
        idle(1);
        check("unmute_gain", current_gain, 4);

        // Unity gain passes samples unchanged.
        tgt_nxt = 8'd128;
        for (int f = 0; f < 400 && m_gain != 128; f++) send_frame(100);
        idle(1);
        check("unity_gain", current_gain, 128);
        send_beat(24'h100000, 0, 100);
        send_beat(24'hF00000, 1, 100);

        // Saturation at the largest gain.
        tgt_nxt = 8'd255;
        for (int f = 0; f < 400 && m_gain != 255; f++) send_frame(100);
        idle(1);
        check("max_gain", current_gain, 255);
        send_beat(24'h7FFFFF, 0, 100);
        send_beat(24'h800000, 1, 100);
        send_beat(24'h400000, 0, 100);
        send_beat(24'hC00000, 1, 100);
        drain();

        // Random sink stalls, continuous source, wandering target and mute.
        lat_check = 0;
        for (int f = 0; f < 500; f++) begin
            if (f % 50 == 0) tgt_nxt = GW'($urandom_range(0, 255));
            if (f % 10 == 0) mute_nxt = ($urandom_range(0, 9) == 0);
            send_frame(30);
        end
        mute_nxt = 1'b0;
        drain();
        lat_check = 1;

        // Misplaced last: sticky error, data keeps flowing.
        send_beat(rnd_data(), 1, 100);
        idle(1);
        check("ferr_set", frame_error, 1);
        send_frame(100);
        send_frame(100);
        drain();
        check("ferr_sticky", frame_error, 1);

        // Reset with two beats in flight discards them.
        cycle(1, rnd_data(), 0, 0, acc);
        cycle(1, rnd_data(), 1, 0, acc);
        do_reset();
        idle(5);
        send_frame(100);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/axis_gain_ramp.md
# axis_gain_ramp

Multi-channel AXI-Stream gain stage with click-free gain changes: scales each signed sample by a per-frame gain that ramps one step at a time toward a target, with mute and output saturation. Sits between the I2S2 receive stream and the I2S2 transmit stream in place of the fixed switch-driven volume stage. It is generalised in data width, channel count and gain resolution, and adds ramping, mute, saturation and frame checking.

## Interface
Parameters:
- DATA_WIDTH, 24, signed sample width.
- CHANNELS, 2, samples per frame; the last sample of a frame carries `last`. Minimum value 1.
- GAIN_WIDTH, 8, unsigned gain width. Unity gain is 2^(GAIN_WIDTH-1).
- RAMP_FRAMES, 1, number of frames between gain steps. Minimum value 1.

Ports:
- clk  in  1  system clock; the sole clock.
- reset  in  1  synchronous, active-high reset.
- target_gain  in  GAIN_WIDTH  requested gain; sampled only at a gain-step instant.
- mute  in  1  when 1, the effective target is 0.
- s_axis_data  in  DATA_WIDTH  input sample, two's complement.
- s_axis_valid  in  1  input valid.
- s_axis_ready  out  1  input ready.
- s_axis_last  in  1  marks the final channel of a frame.
- m_axis_data  out  DATA_WIDTH  scaled sample.
- m_axis_valid  out  1  output valid.
- m_axis_ready  in  1  output ready.
- m_axis_last  out  1  `last` passed through with its sample.
- current_gain  out  GAIN_WIDTH  gain applied to the current frame.
- ramp_busy  out  1  high while current_gain differs from the effective target.
- frame_error  out  1  sticky flag for a misplaced or missing `last`.

## Operation
- **Effective target:** `eff = mute ? 0 : target_gain`.
- **Channel counter (ch):**
  - Increments on each accepted input beat (s_axis_valid && s_axis_ready).
  - Resets to 0 on an accepted beat with `last`=1.
  - Wraps to 0 after CHANNELS-1 regardless of `last`.
- **Frame boundary:** an accepted beat with `last`=1.
- **frame_error:** set if `last`=1 arrives with ch≠CHANNELS-1, or if `last`=0 arrives with ch=CHANNELS-1. It stays high until reset. Data still flows and `last` is passed through unchanged.
- **Frame counter (fc):** counts frame boundaries from 0 to RAMP_FRAMES-1.
  - On the boundary where fc=RAMP_FRAMES-1, fc returns to 0 and a gain step occurs.
  - Gain step: current_gain moves by exactly 1 toward eff. If current_gain already equals eff, it is unchanged.
- **Gain latching:** current_gain changes only on the clock edge after a frame boundary. Every channel of a frame therefore uses the same gain.
- **Arithmetic:**
  - Form the signed product `p = data × {1'b0, gain}`, width DATA_WIDTH+GAIN_WIDTH+1.
  - Compute `q = p >>> (GAIN_WIDTH-1)` (arithmetic shift, which floors).
  - Saturate q to the range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- **Pipeline:** two stages, each with its own valid bit.
  - Stage 1 registers the product, `last`, and the gain in force on the acceptance cycle.
  - Stage 2 registers the shifted, saturated result and `last`; it drives the m_axis outputs.
  - Stage 2 loads when it is empty or m_axis_ready=1. Stage 1 loads when it is empty or stage 2 loads.
  - `s_axis_ready = !v1 || !v2 || m_axis_ready`. This is combinational from register state and m_axis_ready only; it never depends on s_axis_valid.
- **AXIS rules:** no beat is ever dropped or duplicated. m_axis_data and m_axis_last stay stable while m_axis_valid=1 and m_axis_ready=0.
- **Reset values:**
  - Pipeline valid bits are 0, so m_axis_valid=0, m_axis_data=0 and m_axis_last=0.
  - s_axis_ready=1.
  - current_gain=0, which gives a soft start.
  - ch=0, fc=0, frame_error=0, and ramp_busy reflects eff≠0.
  - A reset mid-stream discards every in-flight beat.

## Timing
- With m_axis_ready held at 1, latency is 2 cycles and throughput is 1 beat per cycle.
- Under stall, up to 2 beats are held internally, and s_axis_ready drops once both stages are full.
- A new eff value takes effect at the next gain step. It never applies mid-frame.
- A full ramp from 0 to gain G takes G × RAMP_FRAMES frames.
- ramp_busy is registered alongside current_gain and updates in the same cycle. It also updates within 1 cycle of an eff change.
- If mute and a target change occur together, mute wins.

## Test plan
All tests use DATA_WIDTH=24, GAIN_WIDTH=8 and CHANNELS=2 unless noted.
- **Unity:** hold target=128, step until current_gain=128, send L=0x100000, R=0xF00000 -> outputs 0x100000 and 0xF00000 with `last` on R, 2 cycles latency.
- **Saturation:** at gain=255, input 0x7FFFFF -> 0x7FFFFF; input 0x800000 -> 0x800000; input 0x400000 -> 0x7F8000.
- **Ramp:** with RAMP_FRAMES=2, target=4 from reset, send 10 frames -> current_gain is 0,0,1,1,2,2,3,3,4,4 per frame, ramp_busy falls after the 8th frame boundary, and both channels of each frame use the same gain.
- **Mute:** at gain=4, assert mute for 4 frames with RAMP_FRAMES=1 -> gain goes 3,2,1,0 and the output becomes 0 for nonzero input; deassert mute -> gain ramps back to 4.
- **Backpressure:** random m_axis_ready at 30% duty with continuous input for 1000 beats -> output sequence equals the reference model, no loss, data stable while stalled, and s_axis_ready low only when both stages are full.
- **Frame error and reset:** send `last` on L -> frame_error=1 and persists; pulse reset with 2 beats in flight -> m_axis_valid=0 next cycle, current_gain=0, frame_error=0.
